// File: rtl/hazard_ctrl_p_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the long-op state enum, select encoding and width helper.
package hazard_ctrl_p_pkg;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_BUSY = 1'b1
  } long_st_e;

  localparam int SEL_RF = 0;
  localparam int CNT_W  = 3;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_flush_cnt.sv
// Loadable down-counter used to stretch flush windows.
// Load beats clear; clear beats decrement; saturates at zero.
module hazard_flush_cnt
  import hazard_ctrl_p_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_ld,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard controller: forwarding selects, load-use/long-op/miss
// stalls and jump/mispredict flush windows for an in-order core.
module hazard_ctrl_p
  import hazard_ctrl_p_pkg::*;
#(
  parameter  int RW        = 5,
  parameter  int FWD_DEPTH = 2,
  parameter  int LD_LAT    = 1,
  parameter  int FLUSH_J   = 2,
  parameter  int FLUSH_B   = 2,
  localparam int SW        = sel_w(FWD_DEPTH)
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          is_j,
  input  logic          is_b,
  input  logic          is_load,
  input  logic          is_long,
  input  logic          dst_en,
  input  logic [RW-1:0] r_dst,
  input  logic [RW-1:0] r_src1,
  input  logic [RW-1:0] r_src2,
  input  logic          long_fin,
  input  logic          br_resolve,
  input  logic          br_mispredict,
  input  logic          f_cmiss,
  input  logic          f_arrival,
  input  logic          m_cmiss,
  input  logic          m_arrival,
  output logic [SW-1:0] src1_sel,
  output logic [SW-1:0] src2_sel,
  output logic          fd_st,
  output logic          de_st,
  output logic          em_st,
  output logic          mw_st,
  output logic          flush_o,
  output logic          rs1_dep_o
);

  logic [RW-1:0]    r_dsts [FWD_DEPTH];
  logic             r_lds  [FWD_DEPTH];
  logic             r_ikeep;
  logic             r_dkeep;
  long_st_e         r_state;
  long_st_e         w_nstate;
  logic             w_long_st;
  logic             w_imiss_st;
  logic             w_dmiss_st;
  logic             w_ldhaz;
  logic             w_wr;
  logic             w_mp;
  logic             w_jld;
  logic [CNT_W-1:0] w_jcnt;
  logic [CNT_W-1:0] w_bcnt;
  logic             w_unused_b;

  // Branch class is only consumed downstream at resolve time.
  assign w_unused_b = is_b;

  assign w_wr = dst_en & ~flush_o & ~de_st;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        r_dsts[k] <= '0;
        r_lds[k]  <= 1'b0;
      end
    end else if (!em_st) begin
      r_dsts[0] <= w_wr ? r_dst : '0;
      r_lds[0]  <= w_wr & is_load;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        r_dsts[k] <= r_dsts[k-1];
        r_lds[k]  <= r_lds[k-1];
      end
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    src1_sel = SW'(SEL_RF);
    src2_sel = SW'(SEL_RF);
    w_ldhaz  = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (r_src1 != '0 && r_dsts[k] == r_src1)
        src1_sel = SW'(k + 1);
      if (r_src2 != '0 && r_dsts[k] == r_src2)
        src2_sel = SW'(k + 1);
    end
    for (int k = 0; k < LD_LAT; k++) begin
      if (r_lds[k] &&
          ((r_src1 != '0 && r_dsts[k] == r_src1) ||
           (r_src2 != '0 && r_dsts[k] == r_src2)))
        w_ldhaz = 1'b1;
    end
  end

  assign rs1_dep_o = (src1_sel != SW'(SEL_RF));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ikeep <= 1'b0;
      r_dkeep <= 1'b0;
    end else begin
      r_ikeep <= f_cmiss | (r_ikeep & ~f_arrival);
      r_dkeep <= m_cmiss | (r_dkeep & ~m_arrival);
    end
  end

  assign w_imiss_st = ~f_arrival & (f_cmiss | r_ikeep);
  assign w_dmiss_st = ~m_arrival & (m_cmiss | r_dkeep);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= L_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      L_IDLE: if (is_long & ~flush_o) w_nstate = L_BUSY;
      L_BUSY: if (long_fin | flush_o) w_nstate = L_IDLE;
      default: w_nstate = L_IDLE;
    endcase
  end

  always_comb begin
    w_long_st = 1'b0;
    unique case (r_state)
      L_IDLE: w_long_st = is_long & ~flush_o & ~long_fin;
      L_BUSY: w_long_st = ~long_fin;
      default: w_long_st = 1'b0;
    endcase
  end

  assign fd_st = w_long_st | w_imiss_st | w_dmiss_st | w_ldhaz;
  assign de_st = w_ldhaz | w_dmiss_st;
  assign em_st = w_dmiss_st;
  assign mw_st = 1'b0;

  assign w_mp  = br_resolve & br_mispredict;
  assign w_jld = is_j & ~flush_o & ~fd_st;

  hazard_flush_cnt u_jcnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_ld  (w_jld),
    .i_clr (w_mp),
    .i_val (CNT_W'(FLUSH_J)),
    .o_cnt (w_jcnt)
  );

  // Resolve cycle itself flushes combinationally, hence FLUSH_B-1.
  hazard_flush_cnt u_bcnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_ld  (w_mp),
    .i_clr (1'b0),
    .i_val (CNT_W'(FLUSH_B - 1)),
    .o_cnt (w_bcnt)
  );

  assign flush_o = (w_jcnt != '0) | (w_bcnt != '0) | w_mp;

endmodule

// File: doc/hazard_ctrl_p.md
HAZARD_CTRL_P -- requirements
Module: hazard_ctrl_p

Interface
REQ-001 Parameter RW, default 5, register index width.
REQ-002 Parameter FWD_DEPTH, default 2, bypass stages tracked, legal range 1..4.
REQ-003 Parameter LD_LAT, default 1, load-use stall window in stages, legal range 1..FWD_DEPTH.
REQ-004 Parameter FLUSH_J, default 2, flush cycles after a decoded jump, legal range 1..7.
REQ-005 Parameter FLUSH_B, default 2, flush cycles on branch mispredict (resolve cycle included), legal range 1..7.
REQ-006 Derived SW = clog2(FWD_DEPTH+1), forwarding select width.
REQ-007 clk  in  1  clock; rstn  in  1  reset (synchronous, active-low).
REQ-008 is_j, is_b, is_load, is_long, dst_en  in  1 each  decode-stage instruction class flags and destination-write enable.
REQ-009 r_dst, r_src1, r_src2  in  RW each  decode-stage register indices.
REQ-010 long_fin  in  1  multi-cycle (mul/div) unit done.
REQ-011 br_resolve, br_mispredict  in  1 each  branch resolved this cycle, and whether the prediction was wrong.
REQ-012 f_cmiss, f_arrival, m_cmiss, m_arrival  in  1 each  I/D cache miss and refill-arrival pulses.
REQ-013 src1_sel, src2_sel  out  SW each  0 = register file, k = forward from stage k (1 = youngest).
REQ-014 fd_st, de_st, em_st, mw_st  out  1 each  per-boundary stall.
REQ-015 flush_o  out  1  kill younger instructions; rs1_dep_o  out  1  src1_sel nonzero.

Function
REQ-016 dst[1..FWD_DEPTH] and ld[1..FWD_DEPTH] SHALL form shift registers; each edge without em_st, stage 1 takes r_dst (ld takes is_load) when dst_en & ~flush_o & ~de_st, else 0, and stage k takes stage k-1.
REQ-017 While em_st is high all shift stages SHALL hold.
REQ-018 srcN_sel SHALL equal the smallest k with dst[k]==r_srcN and r_srcN!=0, else 0 (youngest match wins).
REQ-019 ldhaz SHALL be high when any k<=LD_LAT has ld[k] and dst[k] equals a nonzero r_src1 or r_src2.
REQ-020 Miss keepers: set on cmiss, cleared on arrival (set wins if both); imiss_st = ~f_arrival&(f_cmiss|ikeep), dmiss_st likewise.
REQ-021 Long-op FSM IDLE->BUSY on is_long & ~flush_o; BUSY->IDLE on long_fin or flush_o; long_st = (IDLE&is_long&~flush_o | BUSY) & ~long_fin.
REQ-022 fd_st = long_st|imiss_st|dmiss_st|ldhaz; de_st = ldhaz|dmiss_st; em_st = dmiss_st; mw_st = 0.
REQ-023 jcnt SHALL load FLUSH_J on is_j & ~flush_o & ~fd_st, otherwise decrement to 0.
REQ-024 bcnt SHALL load FLUSH_B-1 on br_resolve & br_mispredict, otherwise decrement to 0; mispredict load overrides a concurrent jcnt load (jcnt cleared).
REQ-025 flush_o = (jcnt!=0) | (bcnt!=0) | (br_resolve & br_mispredict), combinational from registers and resolve inputs.
REQ-026 Jumps and branches arriving while flush_o is high SHALL be ignored.

Reset
REQ-027 With rstn low at an edge, all dst/ld stages, keepers, jcnt, bcnt SHALL clear and FSM SHALL enter IDLE; thereafter all outputs SHALL be 0 with inputs idle.
REQ-028 Reset mid-long-op or mid-flush SHALL abandon it with no residual stall or flush.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, SW derivation function, and sel encoding constant SEL_RF = 0.
REQ-030 One sub-module hazard_flush_cnt (load/decrement counter, width 3) SHALL be instantiated twice for jcnt and bcnt.

Verification
REQ-031 FWD_DEPTH=3: write x5 at cycles 0,1; read x5 at cycle 2 -> src1_sel=1; read at cycle 3 -> src1_sel=2... youngest match confirmed.
REQ-032 LD_LAT=1: load x7 then add x7,x7 -> fd_st=de_st=1 one cycle, bubble inserted, then src1_sel=2, rs1_dep_o=1.
REQ-033 is_long then long_fin after 5 cycles -> fd_st high exactly 5 cycles, IDLE after.
REQ-034 FLUSH_J=2 jump -> flush_o high 2 cycles; second jump during flush -> ignored; mispredict with FLUSH_B=3 -> flush_o high 3 cycles from resolve cycle.
REQ-035 m_cmiss pulse, m_arrival 4 cycles later -> fd/de/em_st high 4 cycles, dst stages frozen; rstn low mid-miss -> all stalls 0 next cycle.
